// File: rtl/regfile_bist.sv
// March-style built-in self test for a 16x16 register file: two write/read sweeps
// with complementary nibble patterns, stopping at the first mismatching register.
module regfile_bist #(
    parameter bit SKIP_R0 = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_addr,
    output logic        writeEn,
    output logic [15:0] writeData,
    output logic [3:0]  dstAddr,
    output logic [3:0]  srcAddr,
    input  logic [15:0] readData1,
    input  logic [15:0] readData2
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [3:0] FIRST_ADDR = SKIP_R0 ? 4'd1 : 4'd0;

    logic [1:0]  state;
    logic        passIdx;
    logic [3:0]  addrCnt;
    logic        passReg;
    logic [3:0]  failAddrReg;

    logic [3:0]  srcIdx;
    logic [15:0] expect1;
    logic [15:0] expect2;
    logic        mismatch1;
    logic        mismatch2;
    logic        lastAddr;

    function automatic logic [15:0] pattern(input logic [3:0] a, input logic inv);
        logic [15:0] base;
        base = {a, ~a, a, ~a};
        return inv ? ~base : base;
    endfunction

    // The second read port walks the array from the top so both ports see different cells.
    always_comb begin
        srcIdx    = ~addrCnt;
        lastAddr  = (addrCnt == 4'd15);
        expect1   = pattern(addrCnt, passIdx);
        expect2   = (SKIP_R0 && (srcIdx == 4'd0)) ? 16'h0000 : pattern(srcIdx, passIdx);
        mismatch1 = (readData1 != expect1);
        mismatch2 = (readData2 != expect2);
    end

    always_comb begin
        writeEn   = (state == WRITE);
        writeData = (state == WRITE) ? expect1 : 16'h0000;
        dstAddr   = ((state == WRITE) || (state == READ)) ? addrCnt : 4'd0;
        srcAddr   = (state == READ) ? srcIdx : 4'd0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        pass      = passReg;
        fail_addr = failAddrReg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            passIdx     <= 1'b0;
            addrCnt     <= 4'd0;
            passReg     <= 1'b0;
            failAddrReg <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        passReg     <= 1'b0;
                        failAddrReg <= 4'd0;
                        passIdx     <= 1'b0;
                        addrCnt     <= FIRST_ADDR;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    if (lastAddr) begin
                        addrCnt <= FIRST_ADDR;
                        state   <= READ;
                    end else begin
                        addrCnt <= addrCnt + 4'd1;
                    end
                end
                READ: begin
                    // A port-1 miss wins so the reported address is the one being swept upward.
                    if (mismatch1) begin
                        passReg     <= 1'b0;
                        failAddrReg <= addrCnt;
                        state       <= DONE;
                    end else if (mismatch2) begin
                        passReg     <= 1'b0;
                        failAddrReg <= srcIdx;
                        state       <= DONE;
                    end else if (lastAddr) begin
                        addrCnt <= FIRST_ADDR;
                        if (passIdx) begin
                            passReg <= 1'b1;
                            state   <= DONE;
                        end else begin
                            passIdx <= 1'b1;
                            state   <= WRITE;
                        end
                    end else begin
                        addrCnt <= addrCnt + 4'd1;
                    end
                end
                DONE: begin
                    passIdx <= 1'b0;
                    addrCnt <= 4'd0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_bist.sv
// Self-checking bench for regfile_bist: behavioural register-file models with
// selectable faults, plus a second instance with register 0 hardwired to zero.
module tb_regfile_bist;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sStart;

    logic        busy, done, pass, writeEn;
    logic [3:0]  failAddr, dstAddr, srcAddr;
    logic [15:0] writeData, readData1, readData2;

    logic        sBusy, sDone, sPass, sWriteEn;
    logic [3:0]  sFailAddr, sDstAddr, sSrcAddr;
    logic [15:0] sWriteData, sReadData1, sReadData2;

    logic [15:0] mem  [16];
    logic [15:0] sMem [16];
    int          faultMode;
    logic [3:0]  physDst, physSrc;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    regfile_bist #(.SKIP_R0(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .pass(pass), .fail_addr(failAddr), .writeEn(writeEn), .writeData(writeData),
        .dstAddr(dstAddr), .srcAddr(srcAddr), .readData1(readData1), .readData2(readData2)
    );

    regfile_bist #(.SKIP_R0(1'b1)) dutSkip (
        .clk(clk), .reset(reset), .start(sStart), .busy(sBusy), .done(sDone),
        .pass(sPass), .fail_addr(sFailAddr), .writeEn(sWriteEn), .writeData(sWriteData),
        .dstAddr(sDstAddr), .srcAddr(sSrcAddr), .readData1(sReadData1), .readData2(sReadData2)
    );

    // Mode 1: bit 7 of r9 stuck at 0; mode 2: r11 aliases r3; mode 3: r2 and r13 read inverted.
    always_comb begin
        physDst   = (faultMode == 2 && dstAddr == 4'd11) ? 4'd3 : dstAddr;
        physSrc   = (faultMode == 2 && srcAddr == 4'd11) ? 4'd3 : srcAddr;
        readData1 = mem[physDst];
        readData2 = mem[physSrc];
        if (faultMode == 1 && physDst == 4'd9) readData1[7] = 1'b0;
        if (faultMode == 1 && physSrc == 4'd9) readData2[7] = 1'b0;
        if (faultMode == 3 && (physDst == 4'd2 || physDst == 4'd13)) readData1 = ~readData1;
        if (faultMode == 3 && (physSrc == 4'd2 || physSrc == 4'd13)) readData2 = ~readData2;
    end

    always_comb begin
        sReadData1 = (sDstAddr == 4'd0) ? 16'h0000 : sMem[sDstAddr];
        sReadData2 = (sSrcAddr == 4'd0) ? 16'h0000 : sMem[sSrcAddr];
    end

    always @(posedge clk) begin
        if (writeEn) mem[physDst] <= writeData;
        if (sWriteEn && sDstAddr != 4'd0) sMem[sDstAddr] <= sWriteData;
    end

    function automatic logic [15:0] pat(input logic [3:0] a, input logic inv);
        logic [15:0] b;
        b = {a, ~a, a, ~a};
        return inv ? ~b : b;
    endfunction

    task automatic applyStimulus();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; sStart = 1'b1;
        @(posedge clk); #1;
        assertCount++;
        if (busy !== 1'b0 || sBusy !== 1'b0) begin
            failCount++; $display("FAIL reset_busy: got busy=%b sBusy=%b, expected 0 0", busy, sBusy);
        end
        assertCount++;
        if ({writeEn, writeData, dstAddr, srcAddr} !== 25'd0) begin
            failCount++; $display("FAIL reset_port: got we=%b wd=%h dst=%0d src=%0d, expected all 0", writeEn, writeData, dstAddr, srcAddr);
        end
        assertCount++;
        if ({done, pass, failAddr} !== 6'd0) begin
            failCount++; $display("FAIL reset_status: got done=%b pass=%b failAddr=%0d, expected 0 0 0", done, pass, failAddr);
        end
        reset = 1'b0; start = 1'b0; sStart = 1'b0;
        idleCycles(2);
        assertCount++;
        if (busy !== 1'b0) begin
            failCount++; $display("FAIL reset_idle: got busy=%b, expected 0", busy);
        end
    endtask

    task automatic test_ideal();
        int writes, doneAt, doneCnt;
        logic [3:0] ea;
        logic ep;
        bit inWin;
        writes = 0; doneAt = 0; doneCnt = 0;
        faultMode = 0;
        applyStimulus();
        for (int n = 1; n <= 80; n++) begin
            inWin = 1'b0; ea = 4'd0; ep = 1'b0;
            if (n >= 1 && n <= 16) begin inWin = 1'b1; ea = 4'(n - 1); ep = 1'b0; end
            if (n >= 33 && n <= 48) begin inWin = 1'b1; ea = 4'(n - 33); ep = 1'b1; end
            if (writeEn) begin
                writes++;
                assertCount++;
                if (!inWin || dstAddr !== ea || writeData !== pat(ea, ep)) begin
                    failCount++;
                    $display("FAIL ideal_write c%0d: got dst=%0d wd=%h, expected window=%b dst=%0d wd=%h", n, dstAddr, writeData, inWin, ea, pat(ea, ep));
                end
            end
            if (done) begin doneCnt++; if (doneAt == 0) doneAt = n; end
            if (n == 17 || n == 49) begin
                assertCount++;
                if (writeEn !== 1'b0 || dstAddr !== 4'd0 || srcAddr !== 4'd15) begin
                    failCount++; $display("FAIL ideal_read_start c%0d: got we=%b dst=%0d src=%0d, expected 0 0 15", n, writeEn, dstAddr, srcAddr);
                end
            end
            if (n == 64) begin
                assertCount++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    failCount++; $display("FAIL ideal_busy64: got busy=%b done=%b, expected 1 0", busy, done);
                end
            end
            if (n == 65) begin
                assertCount++;
                if (pass !== 1'b1) begin
                    failCount++; $display("FAIL ideal_pass_at_done: got %b, expected 1", pass);
                end
            end
            @(posedge clk); #1;
        end
        assertCount++;
        if (writes !== 32) begin failCount++; $display("FAIL ideal_write_count: got %0d, expected 32", writes); end
        assertCount++;
        if (doneAt !== 65 || doneCnt !== 1) begin
            failCount++; $display("FAIL ideal_done: got cycle %0d count %0d, expected 65 1", doneAt, doneCnt);
        end
        assertCount++;
        if (pass !== 1'b1 || failAddr !== 4'd0 || busy !== 1'b0) begin
            failCount++; $display("FAIL ideal_result: got pass=%b failAddr=%0d busy=%b, expected 1 0 0", pass, failAddr, busy);
        end
    endtask

    task automatic test_fault(input int mode, input string name, input int probeCycle,
                              input logic [3:0] probeAddr, input int expDone, input logic [3:0] expFail);
        int doneAt;
        doneAt = 0;
        faultMode = mode;
        applyStimulus();
        for (int n = 1; n <= 40; n++) begin
            if (n == probeCycle) begin
                assertCount++;
                if ((mode == 1 ? srcAddr : dstAddr) !== probeAddr) begin
                    failCount++; $display("FAIL %s_probe: got addr %0d, expected %0d", name, (mode == 1 ? srcAddr : dstAddr), probeAddr);
                end
            end
            if (done && doneAt == 0) doneAt = n;
            @(posedge clk); #1;
        end
        assertCount++;
        if (doneAt !== expDone) begin failCount++; $display("FAIL %s_done: got cycle %0d, expected %0d", name, doneAt, expDone); end
        assertCount++;
        if (pass !== 1'b0 || failAddr !== expFail) begin
            failCount++; $display("FAIL %s_result: got pass=%b failAddr=%0d, expected 0 %0d", name, pass, failAddr, expFail);
        end
    endtask

    task automatic test_stuck_bit();
        test_fault(1, "stuck", 23, 4'd9, 24, 4'd9);
    endtask

    task automatic test_alias();
        test_fault(2, "alias", 20, 4'd3, 21, 4'd3);
    endtask

    task automatic test_dual_mismatch();
        test_fault(3, "dual", 19, 4'd2, 20, 4'd2);
    endtask

    task automatic test_reset_midtest();
        int stray, doneAt;
        stray = 0; doneAt = 0;
        faultMode = 0;
        applyStimulus();
        idleCycles(39);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        assertCount++;
        if (writeEn !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            failCount++; $display("FAIL abort_state: got we=%b busy=%b done=%b pass=%b, expected 0 0 0 0", writeEn, busy, done, pass);
        end
        for (int n = 0; n < 40; n++) begin
            if (writeEn || done || busy) stray++;
            @(posedge clk); #1;
        end
        assertCount++;
        if (stray !== 0) begin failCount++; $display("FAIL abort_quiet: got %0d active cycles, expected 0", stray); end
        applyStimulus();
        for (int n = 1; n <= 70; n++) begin
            if (done && doneAt == 0) doneAt = n;
            @(posedge clk); #1;
        end
        assertCount++;
        if (doneAt !== 65 || pass !== 1'b1) begin
            failCount++; $display("FAIL abort_rerun: got done cycle %0d pass=%b, expected 65 1", doneAt, pass);
        end
    endtask

    task automatic test_restart_ignored();
        int writes, doneAt, doneCnt;
        writes = 0; doneAt = 0; doneCnt = 0;
        faultMode = 0;
        applyStimulus();
        for (int n = 1; n <= 80; n++) begin
            start = (n == 10 || n == 50 || n == 65);
            if (writeEn) writes++;
            if (done) begin doneCnt++; if (doneAt == 0) doneAt = n; end
            if (n == 66) begin
                assertCount++;
                if (busy !== 1'b0) begin failCount++; $display("FAIL start_in_done: got busy=%b, expected 0", busy); end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        assertCount++;
        if (writes !== 32 || doneAt !== 65 || doneCnt !== 1) begin
            failCount++; $display("FAIL restart_ignored: got writes=%0d done=%0d count=%0d, expected 32 65 1", writes, doneAt, doneCnt);
        end
    endtask

    task automatic test_back_to_back();
        int doneCnt, lastDone;
        doneCnt = 0; lastDone = 0;
        faultMode = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 140; n++) begin
            if (done) begin doneCnt++; lastDone = n; end
            if (n == 66) begin
                assertCount++;
                if (busy !== 1'b0) begin failCount++; $display("FAIL b2b_idle: got busy=%b, expected 0", busy); end
            end
            if (n == 67) begin
                assertCount++;
                if (busy !== 1'b1 || writeEn !== 1'b1 || dstAddr !== 4'd0) begin
                    failCount++; $display("FAIL b2b_relaunch: got busy=%b we=%b dst=%0d, expected 1 1 0", busy, writeEn, dstAddr);
                end
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        assertCount++;
        if (doneCnt !== 2 || lastDone !== 131 || pass !== 1'b1) begin
            failCount++; $display("FAIL b2b_done: got count=%0d last=%0d pass=%b, expected 2 131 1", doneCnt, lastDone, pass);
        end
    endtask

    task automatic test_skip_r0();
        int writes, doneAt;
        logic [3:0] ea;
        logic ep;
        bit inWin;
        writes = 0; doneAt = 0;
        sStart = 1'b1;
        @(posedge clk); #1;
        sStart = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            inWin = 1'b0; ea = 4'd0; ep = 1'b0;
            if (n >= 1 && n <= 15) begin inWin = 1'b1; ea = 4'(n); ep = 1'b0; end
            if (n >= 31 && n <= 45) begin inWin = 1'b1; ea = 4'(n - 30); ep = 1'b1; end
            if (sWriteEn) begin
                writes++;
                assertCount++;
                if (!inWin || sDstAddr === 4'd0 || sDstAddr !== ea || sWriteData !== pat(ea, ep)) begin
                    failCount++;
                    $display("FAIL skip_write c%0d: got dst=%0d wd=%h, expected window=%b dst=%0d wd=%h", n, sDstAddr, sWriteData, inWin, ea, pat(ea, ep));
                end
            end
            if (n == 30) begin
                assertCount++;
                if (sDstAddr !== 4'd15 || sSrcAddr !== 4'd0) begin
                    failCount++; $display("FAIL skip_last_read: got dst=%0d src=%0d, expected 15 0", sDstAddr, sSrcAddr);
                end
            end
            if (sDone && doneAt == 0) doneAt = n;
            @(posedge clk); #1;
        end
        assertCount++;
        if (writes !== 30 || doneAt !== 61) begin
            failCount++; $display("FAIL skip_timing: got writes=%0d done=%0d, expected 30 61", writes, doneAt);
        end
        assertCount++;
        if (sPass !== 1'b1 || sFailAddr !== 4'd0) begin
            failCount++; $display("FAIL skip_result: got pass=%b failAddr=%0d, expected 1 0", sPass, sFailAddr);
        end
    endtask

    initial begin
        faultMode = 0;
        reset = 1'b1; start = 1'b0; sStart = 1'b0;
        for (int a = 0; a < 16; a++) begin
            mem[a]  = 16'h0000;
            sMem[a] = 16'h0000;
        end
        test_reset();
        test_ideal();
        test_stuck_bit();
        test_alias();
        test_dual_mismatch();
        test_reset_midtest();
        test_restart_ignored();
        test_back_to_back();
        test_skip_r0();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
